// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 matrix datapath: element counts, operand width,
// FSM state encoding and the 9-word buffer type.
package matrix_pkg;

  localparam int MAT_ELEMS   = 9;
  localparam int OPERAND_W   = 13;
  localparam int RESULT_BASE = 64;
  localparam int MAT_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [MAT_DATA_W-1:0] mat_buf_t [MAT_ELEMS];

endpackage

// File: rtl/matrix_sat.sv
// Combinational signed saturate of a DATA_W word to the OPERAND_W operand range,
// sign-extended back to DATA_W.
module matrix_sat
  import matrix_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  localparam int HI_W = DATA_W - OPERAND_W + 1;

  logic sign_w;
  logic in_range_w;

  assign sign_w = d_i[DATA_W-1];
  // In range when every bit above the operand's magnitude field copies the sign.
  assign in_range_w = (d_i[DATA_W-1:OPERAND_W-1] == {HI_W{sign_w}});

  always_comb begin
    if (in_range_w) begin
      q_o = d_i;
    end else if (sign_w) begin
      q_o = {{HI_W{1'b1}}, {(OPERAND_W-1){1'b0}}};
    end else begin
      q_o = {{HI_W{1'b0}}, {(OPERAND_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/matrix_store_unit.sv
// Captures the 3x3 result matrix on store_start and streams it to data memory as nine
// granted writes at descending addresses. MATRIX_STORE_SAT_EN saturates words to 13-bit operands.
module matrix_store_unit
  import matrix_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int MIN_BASE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              store_start,
  input  logic [ADDR_W-1:0] store_base_addr,
  input  logic [DATA_W-1:0] R_11,
  input  logic [DATA_W-1:0] R_12,
  input  logic [DATA_W-1:0] R_13,
  input  logic [DATA_W-1:0] R_21,
  input  logic [DATA_W-1:0] R_22,
  input  logic [DATA_W-1:0] R_23,
  input  logic [DATA_W-1:0] R_31,
  input  logic [DATA_W-1:0] R_32,
  input  logic [DATA_W-1:0] R_33,
  input  logic              mem_grant,
  output logic              mem_write_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done_storing,
  output logic              store_err
);

  typedef logic [DATA_W-1:0] word_t;

  localparam logic [3:0] LAST_K = 4'(MAT_ELEMS - 1);

  word_t raw_w [MAT_ELEMS];
  word_t cap_w [MAT_ELEMS];

  assign raw_w[0] = R_11;
  assign raw_w[1] = R_12;
  assign raw_w[2] = R_13;
  assign raw_w[3] = R_21;
  assign raw_w[4] = R_22;
  assign raw_w[5] = R_23;
  assign raw_w[6] = R_31;
  assign raw_w[7] = R_32;
  assign raw_w[8] = R_33;

`ifdef MATRIX_STORE_SAT_EN
  for (genvar gi = 0; gi < MAT_ELEMS; gi++) begin : g_sat
    matrix_sat #(.DATA_W(DATA_W)) u_sat (
      .d_i (raw_w[gi]),
      .q_o (cap_w[gi])
    );
  end
`else
  assign cap_w = raw_w;
`endif

  state_t            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [3:0]        k_nxt_w;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  word_t             wdata_q, wdata_d;
  word_t             buf_q [MAT_ELEMS];
  word_t             buf_d [MAT_ELEMS];
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              start_ok_w;

  assign start_ok_w = (store_base_addr >= ADDR_W'(MIN_BASE));
  assign k_nxt_w    = k_q + 4'd1;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    req_d   = req_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (store_start) begin
          if (start_ok_w) begin
            buf_d   = cap_w;
            base_d  = store_base_addr;
            k_d     = 4'd0;
            addr_d  = store_base_addr;
            wdata_d = cap_w[0];
            req_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // Without a grant the request and its address/data simply hold.
        if (mem_grant) begin
          if (k_q == LAST_K) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            k_d     = k_nxt_w;
            addr_d  = base_q - ADDR_W'(k_nxt_w);
            wdata_d = buf_q[k_nxt_w];
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 4'd0;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign mem_write_req = req_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign busy          = busy_q;
  assign done_storing  = done_q;
  assign store_err     = err_q;

endmodule

// File: tb/tb_matrix_store_unit.sv
// Randomized self-checking bench for matrix_store_unit against a write-list reference model.
module tb_matrix_store_unit;
  import matrix_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        store_start = 1'b0;
  logic        mem_grant = 1'b0;
  logic [9:0]  store_base_addr = '0;
  logic [31:0] rin [9];
  logic        mem_write_req, busy, done_storing, store_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;

  matrix_store_unit dut (
    .clk(clk), .reset(reset), .store_start(store_start), .store_base_addr(store_base_addr),
    .R_11(rin[0]), .R_12(rin[1]), .R_13(rin[2]), .R_21(rin[3]), .R_22(rin[4]),
    .R_23(rin[5]), .R_31(rin[6]), .R_32(rin[7]), .R_33(rin[8]),
    .mem_grant(mem_grant), .mem_write_req(mem_write_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done_storing(done_storing), .store_err(store_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [9:0]  w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  logic [9:0]  e_addr[$];
  logic [31:0] e_data[$];
  int          e_cyc[$];
  int done_cnt, done_cyc, busy_cnt, busy_first, busy_last;
  int err_cnt, err_cyc, req_cnt, req_first, req_last, hold_viol;
  int exp_done;

  function automatic logic [31:0] ref_word(input logic [31:0] w);
`ifdef MATRIX_STORE_SAT_EN
    int s;
    s = $signed(w);
    if (s > 4095) return 32'h0000_0FFF;
    if (s < -4096) return 32'hFFFF_F000;
    return w;
`else
    return w;
`endif
  endfunction

  // Reference: word k goes to base-k on the k-th granted cycle after the start;
  // done follows the ninth grant by one cycle. A reset at cycle rst_cyc truncates it.
  task automatic model(input logic [9:0] base, input mat_buf_t vals, input logic [63:0] stall,
                       input int t0, input int rst_cyc);
    int c, k;
    c = t0 + 1;
    k = 0;
    while (k < 9 && c < rst_cyc) begin
      if (!stall[c]) begin
        e_addr.push_back(base - 10'(k));
        e_data.push_back(ref_word(vals[k]));
        e_cyc.push_back(c);
        k++;
      end
      c++;
    end
    exp_done = (k == 9) ? c : -1;
  endtask

  task automatic run_store(input logic [9:0] base, input mat_buf_t vals, input logic [63:0] stall,
                           input int rst_cyc, input int re_cyc, input logic [9:0] re_base,
                           input bit scramble, input int ncyc);
    logic prev_held;
    logic [9:0] pa;
    logic [31:0] pd;
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    err_cnt = 0; err_cyc = -1; req_cnt = 0; req_first = -1; req_last = -1; hold_viol = 0;
    store_base_addr = base;
    for (int i = 0; i < 9; i++) rin[i] = vals[i];
    store_start = 1'b1;
    mem_grant = 1'($urandom_range(1, 0));
    @(posedge clk); #1;
    store_start = 1'b0;
    prev_held = 1'b0; pa = '0; pd = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (mem_write_req) begin
        req_cnt++;
        if (req_first < 0) req_first = c;
        req_last = c;
      end
      if (prev_held && mem_write_req && (mem_addr !== pa || mem_wdata !== pd)) hold_viol++;
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (done_storing) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (store_err) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = c;
      end
      reset = (c == rst_cyc);
      if (!mem_write_req) mem_grant = 1'($urandom_range(1, 0));
      else mem_grant = !(reset || stall[c]);
      store_start = (c == re_cyc);
      if (c == re_cyc) store_base_addr = re_base;
      if (scramble) for (int i = 0; i < 9; i++) rin[i] = $urandom;
      if (mem_write_req && mem_grant) begin
        w_addr.push_back(mem_addr);
        w_data.push_back(mem_wdata);
        w_cyc.push_back(c);
      end
      prev_held = mem_write_req && !mem_grant;
      pa = mem_addr;
      pd = mem_wdata;
      @(posedge clk); #1;
    end
    reset = 1'b0; store_start = 1'b0; mem_grant = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (mem_write_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_write_req); end
    n_checks++; if (mem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done_storing !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_storing); end
    n_checks++; if (store_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", store_err); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full store with optional stalls; checks the write list, done/busy timing and hold stability.
  task automatic test_store(input string name, input logic [9:0] base, input mat_buf_t vals,
                            input logic [63:0] stall);
    e_addr.delete(); e_data.delete(); e_cyc.delete();
    model(base, vals, stall, 0, 1000);
    run_store(base, vals, stall, -1, -1, '0, 1'b0, exp_done + 3);
    n_checks++;
    if (w_addr.size() !== e_addr.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d writes want %0d", name, w_addr.size(), e_addr.size());
    end
    for (int k = 0; k < e_addr.size() && k < w_addr.size(); k++) begin
      n_checks++;
      if (w_addr[k] !== e_addr[k] || w_data[k] !== e_data[k] || w_cyc[k] !== e_cyc[k]) begin
        n_fail++;
        $display("FAIL %s_write%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 name, k, w_addr[k], w_data[k], w_cyc[k], e_addr[k], e_data[k], e_cyc[k]);
      end
    end
    n_checks++; if (done_cnt !== 1 || done_cyc !== exp_done) begin n_fail++;
      $display("FAIL %s_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", name, done_cnt, done_cyc, exp_done); end
    n_checks++; if (busy_first !== 1 || busy_last !== exp_done || busy_cnt !== exp_done) begin n_fail++;
      $display("FAIL %s_busy: got first=%0d last=%0d cnt=%0d want 1/%0d/%0d", name, busy_first, busy_last, busy_cnt, exp_done, exp_done); end
    n_checks++; if (req_first !== 1 || hold_viol !== 0 || err_cnt !== 0) begin n_fail++;
      $display("FAIL %s_req: got first=%0d holdviol=%0d err=%0d want 1/0/0", name, req_first, hold_viol, err_cnt); end
  endtask

  task automatic test_reject();
    mat_buf_t v;
    logic [9:0] b;
    for (int i = 0; i < 9; i++) v[i] = $urandom;
    for (int it = 0; it < 3; it++) begin
      b = (it == 0) ? 10'd5 : 10'($urandom_range(7, 0));
      run_store(b, v, '0, -1, -1, '0, 1'b0, 6);
      n_checks++; if (err_cnt !== 1 || err_cyc !== 1) begin n_fail++;
        $display("FAIL reject_err base=%0d: got cnt=%0d cyc=%0d want 1/1", b, err_cnt, err_cyc); end
      n_checks++; if (req_cnt !== 0 || busy_cnt !== 0 || done_cnt !== 0) begin n_fail++;
        $display("FAIL reject_quiet base=%0d: got req=%0d busy=%0d done=%0d want 0/0/0", b, req_cnt, busy_cnt, done_cnt); end
    end
  endtask

  // Starts at cycle 4 (busy) and cycle 10 (DONE) are dropped; a start at cycle 11 runs a second store.
  task automatic test_back_to_back();
    mat_buf_t v;
    int re [3] = '{4, 10, 11};
    for (int i = 0; i < 9; i++) v[i] = $urandom;
    for (int t = 0; t < 3; t++) begin
      e_addr.delete(); e_data.delete(); e_cyc.delete();
      model(10'd200, v, '0, 0, 1000);
      if (re[t] == 11) model(10'd300, v, '0, 11, 1000);
      run_store(10'd200, v, '0, -1, re[t], 10'd300, 1'b0, 25);
      n_checks++; if (w_addr.size() !== e_addr.size()) begin n_fail++;
        $display("FAIL b2b%0d_count: got %0d want %0d", re[t], w_addr.size(), e_addr.size()); end
      for (int k = 0; k < e_addr.size() && k < w_addr.size(); k++) begin
        n_checks++;
        if (w_addr[k] !== e_addr[k] || w_data[k] !== e_data[k] || w_cyc[k] !== e_cyc[k]) begin
          n_fail++;
          $display("FAIL b2b%0d_write%0d: got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                   re[t], k, w_addr[k], w_cyc[k], e_addr[k], e_cyc[k]);
        end
      end
      n_checks++; if (done_cnt !== ((re[t] == 11) ? 2 : 1) || err_cnt !== 0) begin n_fail++;
        $display("FAIL b2b%0d_done: got done=%0d err=%0d", re[t], done_cnt, err_cnt); end
    end
  endtask

  task automatic test_isolation_reset();
    mat_buf_t v;
    for (int i = 0; i < 9; i++) v[i] = i + 1;
    e_addr.delete(); e_data.delete(); e_cyc.delete();
    model(10'd64, v, '0, 0, 5);
    run_store(10'd64, v, '0, 5, -1, '0, 1'b1, 12);
    n_checks++; if (w_addr.size() !== 4) begin n_fail++;
      $display("FAIL rst_count: got %0d writes want 4", w_addr.size()); end
    for (int k = 0; k < e_addr.size() && k < w_addr.size(); k++) begin
      n_checks++;
      if (w_addr[k] !== e_addr[k] || w_data[k] !== e_data[k]) begin n_fail++;
        $display("FAIL rst_write%0d: got addr=%0d data=%h want addr=%0d data=%h", k, w_addr[k], w_data[k], e_addr[k], e_data[k]); end
    end
    n_checks++; if (req_last !== 5 || busy_last !== 5 || done_cnt !== 0) begin n_fail++;
      $display("FAIL rst_stop: got reqlast=%0d busylast=%0d done=%0d want 5/5/0", req_last, busy_last, done_cnt); end
  endtask

  task automatic test_saturation();
    mat_buf_t v;
    logic [31:0] want [3];
`ifdef MATRIX_STORE_SAT_EN
    want = '{32'h0000_0FFF, 32'hFFFF_F000, 32'h0000_0064};
`else
    want = '{32'h0000_2000, 32'hFFFF_D000, 32'h0000_0064};
`endif
    v[0] = 32'h0000_2000; v[1] = 32'hFFFF_D000; v[2] = 32'd100;
    v[3] = 32'h0000_0FFF; v[4] = 32'hFFFF_F000; v[5] = 32'h0000_1000;
    v[6] = 32'hFFFF_EFFF; v[7] = $urandom; v[8] = 32'h8000_0000;
    test_store("sat", 10'd64, v, '0);
    for (int k = 0; k < 3 && k < w_data.size(); k++) begin
      n_checks++; if (w_data[k] !== want[k]) begin n_fail++;
        $display("FAIL sat_fixed%0d: got %h want %h", k, w_data[k], want[k]); end
    end
  endtask

  initial begin
    mat_buf_t v;
    logic [63:0] st;
    for (int i = 0; i < 9; i++) rin[i] = '0;
    test_reset();
    for (int i = 0; i < 9; i++) v[i] = i + 1;
    test_store("basic", 10'd64, v, '0);
    test_store("stall", 10'd64, v, 64'h0000_0000_0000_008C);
    test_reject();
    test_back_to_back();
    test_isolation_reset();
    test_saturation();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 9; i++) v[i] = (it % 2) ? $urandom : 32'($signed($urandom_range(10000, 0)) - 5000);
      st = {$urandom, $urandom} & {$urandom, $urandom};
      test_store("rand", (it == 0) ? 10'd8 : 10'($urandom_range(1023, 8)), v, st);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach end within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
